// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak-f[1600] round sequencer: round count, lane
// width, FSM state encoding and the unroll-factor legality check.
package keccak_pkg;

    localparam int unsigned NR    = 24;
    localparam int unsigned RC_W  = 64;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // An unroll factor is usable only if it divides the 24 rounds evenly.
    function automatic bit ur_legal(input int unsigned ur);
        bit ok;
        case (ur)
            1, 2, 3, 4, 6, 8, 12, 24: ok = 1'b1;
            default:                  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/keccak_round_ctrl_if.sv
// Handshake and constant-ROM bundle between the sponge controller, the round
// sequencer and the unrolled round datapath.
interface keccak_round_ctrl_if
    import keccak_pkg::*;
#(
    parameter int unsigned UR = 1
) ();

    logic                 start;
    logic                 abort;
    logic                 ready;
    logic                 busy;
    logic [CNT_W-1:0]     rc_addr;
    logic [UR*RC_W-1:0]   rc_in;
    logic [UR*RC_W-1:0]   rc_out;
    logic                 round_en;
    logic                 first_round;
    logic                 last_round;
    logic                 done;

    modport master (
        output start, abort, rc_in,
        input  ready, busy, rc_addr, rc_out, round_en, first_round, last_round, done
    );

    modport slave (
        input  start, abort, rc_in,
        output ready, busy, rc_addr, rc_out, round_en, first_round, last_round, done
    );

endinterface

// File: rtl/keccak_round_ctrl.sv
// Keccak-f[1600] round sequencer: steps the round index by UR per cycle over 24 rounds.
// Build option KECCAK_RC_REG_EN registers the round constant and adds a PREP cycle.
module keccak_round_ctrl
    import keccak_pkg::*;
#(
    parameter int unsigned UR = 1
) (
    input  logic               clk,
    input  logic               rst,
    keccak_round_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] STEP = CNT_W'(UR);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NR - UR);

    if (!ur_legal(UR)) begin : g_bad_ur
        $error("keccak_round_ctrl: UR=%0d does not divide %0d rounds", UR, NR);
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_run;
    logic             at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // abort overrides everything, including a simultaneous start in IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
`ifdef KECCAK_RC_REG_EN
                        state_d = PREP;
`else
                        state_d = RUN;
`endif
                        cnt_d   = '0;
                    end
                end
                PREP: state_d = RUN;
                RUN: begin
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + STEP;
                    end
                end
                DONE:    state_d = IDLE;
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign in_run  = (state_q == RUN);
    assign at_last = (cnt_q == LAST);

    assign bus.ready       = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.round_en    = in_run;
    assign bus.first_round = in_run && (cnt_q == '0);
    assign bus.last_round  = in_run && at_last;
    assign bus.done        = (state_q == DONE);

`ifdef KECCAK_RC_REG_EN
    logic [UR*RC_W-1:0] rc_q;

    // Fetch one step ahead so the registered constant lines up with round_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc_q <= '0;
        end else if (bus.abort) begin
            rc_q <= '0;
        end else if (state_q == PREP || state_q == RUN) begin
            rc_q <= bus.rc_in;
        end
    end

    assign bus.rc_addr = (in_run && !at_last) ? cnt_q + STEP : '0;
    assign bus.rc_out  = rc_q;
`else
    assign bus.rc_addr = cnt_q;
    assign bus.rc_out  = bus.rc_in;
`endif

endmodule

// File: doc/keccak_round_ctrl.md
# keccak_round_ctrl

Round sequencer for the Keccak-f[1600] permutation used by the SHAKE/SHA3 core. It accepts a start request and steps the round index through 24 rounds in groups of UR rounds per cycle. The index drives the round-constant ROM address; the returned constant goes back to the round datapath together with the state-register enable, and completion is signalled with a done pulse. The block sits between the sponge controller (upstream, start/ready) and the unrolled round datapath plus constant ROM (downstream).

## Interface
- UR, 1, rounds per cycle (unroll factor); legal values 1, 2, 3, 4, 6, 8, 12, 24; any other value is an elaboration-time error
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  permutation request; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE from any state
- ready  out  1  high only in IDLE
- busy  out  1  high in PREP, RUN and DONE
- rc_addr  out  5  round index to the constant ROM
- rc_in  in  UR*64  constants from the ROM; lane i is the constant for round rc_addr+i
- rc_out  out  UR*64  constants aligned with round_en
- round_en  out  1  state-register update enable for the round datapath
- first_round  out  1  round_en high and round index = 0
- last_round  out  1  round_en high and round index = 24-UR
- done  out  1  one-cycle pulse after the last round

## Operation
- States: IDLE, PREP (exists only with the macro), RUN, DONE. The 5-bit round counter cnt steps by UR.
- IDLE:
  - If start=1 and abort=0, go to RUN (or to PREP with the macro) and set cnt=0.
  - Otherwise stay in IDLE.
- PREP: one cycle, rc_addr=0; then go to RUN.
- RUN:
  - round_en=1 every cycle, cnt += UR.
  - When cnt = 24-UR, go to DONE and clear cnt to 0.
- DONE: done=1 for one cycle; start is ignored; then go to IDLE.
- abort=1 in any state:
  - Next state is IDLE, cnt=0, rc register cleared.
  - No done pulse is produced.
  - If abort and start are both high in IDLE, abort wins.
- start outside IDLE is ignored. There is no queuing.
- Arithmetic: cnt never exceeds 23, so there is no wrap. rc_addr+i stays at or below 23 for every legal UR.
- Outputs are decoded from the registered state and counter. They never depend combinationally on start or abort.

## Timing
- Reset values:
  - Registers: state=IDLE, cnt=0, rc register=0.
  - Outputs: ready=1, busy=0, round_en=0, done=0, first_round=0, last_round=0, rc_addr=0, rc_out=0 with the macro.
- Without the macro:
  - rc_addr = cnt (0 in IDLE and DONE).
  - rc_out = rc_in, combinational pass-through.
- Latency with start accepted at cycle 0:
  - round_en is high in cycles 1 to 24/UR.
  - done is high in cycle 24/UR+1.
  - ready returns high in cycle 24/UR+2.
- Back-to-back permutations: at least 2 non-RUN cycles (DONE, then IDLE) between runs.

## Configuration
- Macro: KECCAK_RC_REG_EN.
- Defined:
  - The constant is registered (rc_q <= rc_in in PREP and RUN) and rc_out = rc_q.
  - rc_addr looks one step ahead: 0 in PREP, cnt+UR in RUN, 0 on the last round.
  - PREP adds one cycle: round_en is high in cycles 2 to 24/UR+1, and done is high in cycle 24/UR+2.
  - This removes the ROM from the round-datapath critical path.
- Undefined: PREP does not exist, there is no rc register, and rc_out passes rc_in straight through.

## Structure
- Shared package keccak_pkg holds:
  - NR=24
  - RC_W=64
  - the state enum typedef (IDLE, PREP, RUN, DONE)
  - the legal-UR check function
- No sub-module. The constant ROM is instantiated beside this block, not inside it.

## Test plan
- Reset, UR=1 -> ready=1, busy=0, round_en=0, done=0, rc_addr=0, all held until start.
- UR=1, macro off, one start pulse:
  - round_en high for 24 cycles with rc_addr 0..23.
  - rc_out=0x0000000000000001 with first_round, and 0x8000000080008008 with last_round.
  - done pulse in cycle 25, ready back in cycle 26.
- UR=2, macro off:
  - 12 RUN cycles with rc_addr 0,2,…,22.
  - First cycle: rc_out[63:0]=0x1, rc_out[127:64]=0x8082.
  - done in cycle 13.
- Macro on, UR=1:
  - PREP in cycle 1 with rc_addr=0.
  - round_en in cycles 2–25; rc_out always equals the constant for the current round.
  - done in cycle 26.
- abort at the 11th round_en cycle (cnt=10):
  - Next cycle: IDLE, ready=1, no done pulse.
  - A following start runs a full 24 rounds from cnt=0.
- start held high permanently:
  - start is ignored in RUN and DONE; permutations repeat with exactly 2 gap cycles.
  - abort+start asserted together in IDLE -> stays in IDLE.
